// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: card-side SD CMD line engine; receives 48-bit host commands
// and returns user-supplied R1/R3/R6/R7 responses after the NCR gap.
module sd_cmd_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NCR_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sdclk,
    input  logic        sdcmd_i,
    output logic        sdcmd_o,
    output logic        sdcmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_err,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic        rsp_none,
    input  logic        rsp_nocrc,
    input  logic [5:0]  rsp_index,
    input  logic [31:0] rsp_arg,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT_RSP, NCR, TX} state_t;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 39; i >= 0; i--)
            c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
        return c;
    endfunction

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_cmd_sync;
    logic                   r_clk_prev;
    logic [47:0]            r_rx;
    logic [47:0]            r_tx;
    logic [5:0]             r_cnt;
    logic [6:0]             r_ncr;
    logic                   r_sdcmd_o;
    logic                   r_sdcmd_oe;
    logic                   r_cmd_valid;
    logic                   r_cmd_crc_err;
    logic [5:0]             r_cmd_index;
    logic [31:0]            r_cmd_arg;
    logic                   r_rsp_ready;

    logic        w_clk_s;
    logic        w_cmd_s;
    logic        w_rise;
    logic        w_fall;
    logic        w_host_start;
    logic        w_rx_ok;
    logic [6:0]  w_ncr_inc;
    logic [47:0] w_rsp_frame;

    always_comb begin
        w_clk_s      = r_clk_sync[SYNC_STAGES-1];
        w_cmd_s      = r_cmd_sync[SYNC_STAGES-1];
        w_rise       = w_clk_s & ~r_clk_prev;
        w_fall       = ~w_clk_s & r_clk_prev;
        w_host_start = w_rise & ~w_cmd_s;
        w_rx_ok      = r_rx[46] & r_rx[0] & (crc7(r_rx[47:8]) == r_rx[7:1]);
        w_ncr_inc    = (r_ncr == 7'd64) ? r_ncr : r_ncr + 7'd1;
        w_rsp_frame  = {2'b00, rsp_index, rsp_arg,
                        rsp_nocrc ? 7'h7F : crc7({2'b00, rsp_index, rsp_arg}), 1'b1};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_clk_sync <= '1;
            r_cmd_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], sdclk};
            r_cmd_sync <= {r_cmd_sync[SYNC_STAGES-2:0], sdcmd_i};
            r_clk_prev <= w_clk_s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_rx          <= '0;
            r_tx          <= '1;
            r_cnt         <= '0;
            r_ncr         <= '0;
            r_sdcmd_o     <= 1'b1;
            r_sdcmd_oe    <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_crc_err <= 1'b0;
            r_cmd_index   <= '0;
            r_cmd_arg     <= '0;
            r_rsp_ready   <= 1'b0;
        end else begin
            r_cmd_valid   <= 1'b0;
            r_cmd_crc_err <= 1'b0;
            case (r_state)
                IDLE: if (w_host_start) begin
                    r_state <= RX;
                    r_cnt   <= 6'd1;
                    r_rx    <= {r_rx[46:0], w_cmd_s};
                end
                RX: if (w_rise) begin
                    r_rx  <= {r_rx[46:0], w_cmd_s};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd47) r_state <= CHECK;
                end
                CHECK: begin
                    r_ncr <= '0;
                    if (w_rx_ok) begin
                        r_cmd_index <= r_rx[45:40];
                        r_cmd_arg   <= r_rx[39:8];
                        r_cmd_valid <= 1'b1;
                        r_rsp_ready <= 1'b1;
                        r_state     <= WAIT_RSP;
                    end else begin
                        r_cmd_crc_err <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                WAIT_RSP: begin
                    if (w_fall) r_ncr <= w_ncr_inc;
                    // a new host command takes priority over a pending response
                    if (w_host_start) begin
                        r_state     <= RX;
                        r_cnt       <= 6'd1;
                        r_rx        <= {r_rx[46:0], w_cmd_s};
                        r_rsp_ready <= 1'b0;
                    end else if (rsp_valid && r_rsp_ready) begin
                        r_rsp_ready <= 1'b0;
                        r_tx        <= w_rsp_frame;
                        r_state     <= rsp_none ? IDLE : NCR;
                    end
                end
                NCR: if (w_fall) begin
                    r_ncr <= w_ncr_inc;
                    if (w_ncr_inc >= 7'(NCR_CYCLES)) begin
                        r_state    <= TX;
                        r_sdcmd_oe <= 1'b1;
                        r_sdcmd_o  <= r_tx[47];
                        r_cnt      <= 6'd1;
                    end
                end
                TX: if (w_fall) begin
                    if (r_cnt == 6'd48) begin
                        r_sdcmd_oe <= 1'b0;
                        r_sdcmd_o  <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_sdcmd_o <= r_tx[46];
                        r_tx      <= {r_tx[46:0], 1'b1};
                        r_cnt     <= r_cnt + 6'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sdcmd_o     = r_sdcmd_o;
    assign sdcmd_oe    = r_sdcmd_oe;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_index   = r_cmd_index;
    assign cmd_arg     = r_cmd_arg;
    assign cmd_crc_err = r_cmd_crc_err;
    assign rsp_ready   = r_rsp_ready;
    assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb_sd_cmd_responder: scoreboard bench; stimulus pushes expected command
// events and response frames, monitors pop and compare what the DUT produces.
module tb_sd_cmd_responder;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sdclk = 1'b0;
    logic        host_cmd = 1'b1;
    logic        sdcmd_o, sdcmd_oe, cmd_valid, cmd_crc_err, rsp_ready, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        rsp_valid = 1'b0, rsp_none = 1'b0, rsp_nocrc = 1'b0;
    logic [5:0]  rsp_index = '0;
    logic [31:0] rsp_arg = '0;

    typedef struct { logic err; logic [5:0] idx; logic [31:0] arg; } cmd_exp_t;
    typedef struct { logic [47:0] frame; int start; logic abort; } rsp_exp_t;
    cmd_exp_t qc[$];
    rsp_exp_t qr[$];
    int n_chk = 0, n_pass = 0, nfall = 0, n_oe = 0, end_nf = 0, save_oe;

    sd_cmd_responder #(.SYNC_STAGES(2), .NCR_CYCLES(2)) dut (
        .clk(clk), .rstn(rstn), .sdclk(sdclk), .sdcmd_i(host_cmd),
        .sdcmd_o(sdcmd_o), .sdcmd_oe(sdcmd_oe), .cmd_valid(cmd_valid),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc_err(cmd_crc_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_none(rsp_none),
        .rsp_nocrc(rsp_nocrc), .rsp_index(rsp_index), .rsp_arg(rsp_arg), .busy(busy)
    );

    always #5 clk = ~clk;
    always #40 sdclk = ~sdclk;
    always @(negedge sdclk) nfall <= nfall + 1;
    always @(posedge sdcmd_oe) n_oe <= n_oe + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 39; i >= 0; i--)
            c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
        return c;
    endfunction

    task automatic send(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sdclk);
            host_cmd = f[i];
        end
        end_nf = nfall;
        @(negedge sdclk);
        host_cmd = 1'b1;
    endtask

    task automatic setrsp(input logic v, input logic none, input logic nocrc,
                          input logic [5:0] idx, input logic [31:0] arg);
        rsp_valid = v; rsp_none = none; rsp_nocrc = nocrc; rsp_index = idx; rsp_arg = arg;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, busy, 0);
    endtask

    // command-event monitor
    initial begin
        cmd_exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && (cmd_valid || cmd_crc_err)) begin
                chk("cmd_excl", cmd_valid & cmd_crc_err, 0);
                chk("cmd_q", qc.size() > 0, 1);
                if (qc.size() > 0) begin
                    e = qc.pop_front();
                    chk("cmd_err", cmd_crc_err, e.err);
                    chk("cmd_index", cmd_index, e.idx);
                    chk("cmd_arg", cmd_arg, e.arg);
                end
            end
        end
    end

    // response-line monitor, samples the bit driven on the previous fall
    initial begin
        rsp_exp_t e;
        logic cap;
        int rcnt, rstart;
        logic [47:0] rsh;
        cap = 1'b0; rcnt = 0; rstart = 0; rsh = '0;
        forever begin
            @(negedge sdclk);
            if (!rstn) begin
                if (cap) begin
                    cap = 1'b0;
                    chk("rsp_q", qr.size() > 0, 1);
                    if (qr.size() > 0) begin
                        e = qr.pop_front();
                        chk("rsp_abort", e.abort, 1);
                    end
                end
            end else if (!cap) begin
                if (sdcmd_oe && !sdcmd_o) begin
                    cap = 1'b1; rcnt = 1; rsh = '0; rstart = nfall;
                end
            end else begin
                rsh = {rsh[46:0], sdcmd_o};
                rcnt++;
                if (rcnt == 48) begin
                    cap = 1'b0;
                    chk("rsp_q", qr.size() > 0, 1);
                    if (qr.size() > 0) begin
                        e = qr.pop_front();
                        chk("rsp_frame", rsh, e.frame);
                        chk("rsp_abort", e.abort, 0);
                        if (e.start >= 0) chk("rsp_start", rstart, e.start);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] c41;
        c41 = {8'h69, 32'h40FF8000};
        #23;
        chk("rst_o", sdcmd_o, 1);
        chk("rst_oe", sdcmd_oe, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_err", cmd_crc_err, 0);
        chk("rst_index", cmd_index, 0);
        chk("rst_arg", cmd_arg, 0);
        chk("rst_ready", rsp_ready, 0);
        chk("rst_busy", busy, 0);
        #80;
        @(negedge clk) rstn = 1'b1;
        repeat (20) @(negedge clk);

        // CMD0, no response
        save_oe = n_oe;
        setrsp(1, 1, 0, 6'd0, 32'd0);
        qc.push_back('{err: 1'b0, idx: 6'd0, arg: 32'd0});
        send(48'h40_00000000_95);
        wait_idle("t1_idle");
        repeat (40) @(negedge clk);
        chk("t1_no_oe", n_oe - save_oe, 0);

        // CMD8 with R7
        setrsp(1, 0, 0, 6'd8, 32'h1AA);
        qc.push_back('{err: 1'b0, idx: 6'd8, arg: 32'h1AA});
        qr.push_back('{frame: 48'h08_000001AA_13, start: -1, abort: 1'b0});
        send(48'h48_000001AA_87);
        qr[$].start = end_nf + 3;
        wait_idle("t2_idle");
        chk("t2_oe_off", sdcmd_oe, 0);

        // CMD41 with R3
        setrsp(1, 0, 1, 6'h3F, 32'h80FF8000);
        qc.push_back('{err: 1'b0, idx: 6'd41, arg: 32'h40FF8000});
        qr.push_back('{frame: 48'h3F_80FF8000_FF, start: -1, abort: 1'b0});
        send({c41, crc7(c41), 1'b1});
        qr[$].start = end_nf + 3;
        wait_idle("t4_idle");

        // bad CRC keeps the CMD41 fields
        save_oe = n_oe;
        setrsp(0, 0, 0, 6'd0, 32'd0);
        qc.push_back('{err: 1'b1, idx: 6'd41, arg: 32'h40FF8000});
        send(48'h48_000001AA_94);
        wait_idle("t3_idle");
        repeat (40) @(negedge clk);
        chk("t3_no_oe", n_oe - save_oe, 0);
        chk("t3_index_held", cmd_index, 6'd41);

        // delayed response
        qc.push_back('{err: 1'b0, idx: 6'd8, arg: 32'h1AA});
        qr.push_back('{frame: 48'h08_000001AA_13, start: -1, abort: 1'b0});
        send(48'h48_000001AA_87);
        repeat (200) @(posedge sdclk);
        chk("t5_ready", rsp_ready, 1);
        chk("t5_busy", busy, 1);
        qr[$].start = nfall + 1;
        setrsp(1, 0, 0, 6'd8, 32'h1AA);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!rsp_ready) break;
        end
        chk("t5_hs", rsp_ready, 0);
        rsp_valid = 1'b0;
        wait_idle("t5_idle");

        // reset in the middle of a response
        setrsp(1, 0, 0, 6'd8, 32'h1AA);
        qc.push_back('{err: 1'b0, idx: 6'd8, arg: 32'h1AA});
        qr.push_back('{frame: 48'h0, start: -1, abort: 1'b1});
        send(48'h48_000001AA_87);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sdcmd_oe) break;
        end
        chk("t6_oe_on", sdcmd_oe, 1);
        repeat (20) @(negedge sdclk);
        #5 rstn = 1'b0;
        #1;
        chk("t6_oe_drop", sdcmd_oe, 0);
        chk("t6_o", sdcmd_o, 1);
        chk("t6_busy", busy, 0);
        chk("t6_index", cmd_index, 0);
        chk("t6_arg", cmd_arg, 0);
        rsp_valid = 1'b0;
        #100;
        @(negedge clk) rstn = 1'b1;
        repeat (10) @(negedge clk);
        setrsp(1, 1, 0, 6'd0, 32'd0);
        qc.push_back('{err: 1'b0, idx: 6'd0, arg: 32'd0});
        send(48'h40_00000000_95);
        wait_idle("t6_idle");

        repeat (100) @(negedge clk);
        chk("qc_empty", qc.size(), 0);
        chk("qr_empty", qr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
